uart_rx_fifo: RTL and testbench

Receive buffer placed directly downstream of the UART receiver. It captures each received byte on the receiver's completion pulse and holds it in a circular buffer. The AXI-Lite register interface pops bytes from the buffer through a simple read strobe. Status outputs (empty, full, count, almost-full, sticky overrun) feed the status register and the interrupt logic.

---
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_rx_fifo.sv | 98 +++++++++
 tb/tb_uart_rx_fifo.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Purpose: bundles the receive-buffer push, pop, control and status signals.
// Latency: none, wiring only.
// Backpressure: none here; the buffer drops on full and ignores pops on empty.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              rx_done;
    logic [7:0]        rx_data;
    logic              rd_en;
    logic              flush;
    logic              clr_overrun;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overrun;

    // Requester side: receiver plus register interface.
    modport master (
        output rx_done, rx_data, rd_en, flush, clr_overrun,
        input  rd_data, rd_valid, empty, full, almost_full, count, overrun
    );

    // Buffer side.
    modport slave (
        input  rx_done, rx_data, rd_en, flush, clr_overrun,
        output rd_data, rd_valid, empty, full, almost_full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: circular byte buffer between the UART receiver and the register read port.
// Latency: write lands on the rx_done rising edge; pop data appears one cycle after rd_en.
// Backpressure: none; a byte arriving while full is dropped and flagged as sticky overrun.
module uart_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic            clk,
    input  logic            a_resetn,
    uart_rx_fifo_if.slave   bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_THRESH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   cnt;
    logic              rx_done_q;
    logic [7:0]        rd_data_q;
    logic              rd_valid_q;
    logic              overrun_q;

    logic              empty_w;
    logic              full_w;
    logic              wr_req;
    logic              rd_ok;
    logic              wr_ok;
    logic              ovr_evt;

    // Status is a pure function of the occupancy counter, never of pointer comparison.
    assign empty_w = (cnt == '0);
    assign full_w  = (cnt == DEPTH_C);

    // A pop on a full buffer frees the slot the simultaneous push needs.
    assign wr_req  = bus.rx_done & ~rx_done_q;
    assign rd_ok   = bus.rd_en & ~empty_w;
    assign wr_ok   = wr_req & (~full_w | rd_ok);
    assign ovr_evt = wr_req & full_w & ~rd_ok;

    // Storage has no reset; flush blocks the write so the slot is not claimed.
    always_ff @(posedge clk) begin
        if (wr_ok && !bus.flush) begin
            mem[wptr] <= bus.rx_data;
        end
    end

    // Pointers, occupancy, read port and flags; flush wins over any push/pop.
    always_ff @(posedge clk or negedge a_resetn) begin
        if (!a_resetn) begin
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            rx_done_q  <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_done_q <= bus.rx_done;

            if (ovr_evt) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_overrun) begin
                overrun_q <= 1'b0;
            end

            if (bus.flush) begin
                wptr       <= '0;
                rptr       <= '0;
                cnt        <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_ok;
                if (rd_ok) begin
                    rd_data_q <= mem[rptr];
                    rptr      <= rptr + 1'b1;
                end
                if (wr_ok) begin
                    wptr <= wptr + 1'b1;
                end
                case ({wr_ok, rd_ok})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.almost_full = (cnt >= AFULL_C);
    assign bus.count       = cnt;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: directed checks of the receive buffer: ordering, edge detect, overrun, wrap, flush, reset.
// Latency: outputs sampled 1ns after the rising edge that produced them.
// Backpressure: exercised through full/overrun and empty/ignored-pop cases.
module tb_uart_rx_fifo;
    logic clk;
    logic a_resetn;
    int   total;
    int   bad;

    uart_rx_fifo_if #(.ADDR_W(4)) bus ();

    uart_rx_fifo #(
        .DEPTH        (16),
        .ADDR_W       (4),
        .AFULL_THRESH (12)
    ) dut (
        .clk      (clk),
        .a_resetn (a_resetn),
        .bus      (bus)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One rx_done pulse carrying byte b; the write happens on the first edge.
    task automatic push(input logic [7:0] b);
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        step();
        bus.rx_done = 1'b0;
        step();
    endtask

    // Single-cycle pop, checks returned byte.
    task automatic pop_chk(input string tag, input logic [7:0] b);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, "_dat"}, 32'(bus.rd_data), 32'(b));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
        chk({tag, "_full"}, 32'(bus.full), 32'd0);
        chk({tag, "_afull"}, 32'(bus.almost_full), 32'd0);
        chk({tag, "_rdvld"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, "_rddat"}, 32'(bus.rd_data), 32'h00);
        chk({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        a_resetn        = 1'b0;
        bus.rx_done     = 1'b0;
        bus.rx_data     = 8'h00;
        bus.rd_en       = 1'b0;
        bus.flush       = 1'b0;
        bus.clr_overrun = 1'b0;

        // Reset state.
        step();
        step();
        chk_reset_vals("rst");
        a_resetn = 1'b1;
        step();

        // Three bytes in, three consecutive pops out.
        push(8'h41);
        chk("t1_cnt1", 32'(bus.count), 32'd1);
        push(8'h42);
        chk("t1_cnt2", 32'(bus.count), 32'd2);
        push(8'h43);
        chk("t1_cnt3", 32'(bus.count), 32'd3);
        bus.rd_en = 1'b1;
        step();
        chk("t1_v1", 32'(bus.rd_valid), 32'd1);
        chk("t1_d1", 32'(bus.rd_data), 32'h41);
        chk("t1_c2", 32'(bus.count), 32'd2);
        step();
        chk("t1_v2", 32'(bus.rd_valid), 32'd1);
        chk("t1_d2", 32'(bus.rd_data), 32'h42);
        chk("t1_c1", 32'(bus.count), 32'd1);
        step();
        chk("t1_v3", 32'(bus.rd_valid), 32'd1);
        chk("t1_d3", 32'(bus.rd_data), 32'h43);
        chk("t1_c0", 32'(bus.count), 32'd0);
        bus.rd_en = 1'b0;
        step();
        chk("t1_vend", 32'(bus.rd_valid), 32'd0);
        chk("t1_empty", 32'(bus.empty), 32'd1);

        // Pop on empty is ignored and rd_data holds.
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk("emp_rdvld", 32'(bus.rd_valid), 32'd0);
        chk("emp_rddat", 32'(bus.rd_data), 32'h43);
        chk("emp_cnt", 32'(bus.count), 32'd0);

        // rx_done held high for 5 cycles gives one write.
        bus.rx_done = 1'b1;
        bus.rx_data = 8'h55;
        for (int i = 0; i < 5; i++) step();
        bus.rx_done = 1'b0;
        step();
        chk("t2_cnt", 32'(bus.count), 32'd1);
        pop_chk("t2_pop", 8'h55);
        chk("t2_empty", 32'(bus.empty), 32'd1);

        // Fill to 16, 17th byte dropped with overrun.
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t3_full", 32'(bus.full), 32'd1);
        chk("t3_cnt", 32'(bus.count), 32'd16);
        chk("t3_afull", 32'(bus.almost_full), 32'd1);
        chk("t3_ovr0", 32'(bus.overrun), 32'd0);
        push(8'hAA);
        chk("t3_ovr1", 32'(bus.overrun), 32'd1);
        chk("t3_cnt_drop", 32'(bus.count), 32'd16);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("t3_rd%0d", i), 8'(i));
        chk("t3_empty", 32'(bus.empty), 32'd1);
        chk("t3_ovr_sticky", 32'(bus.overrun), 32'd1);
        bus.clr_overrun = 1'b1;
        step();
        bus.clr_overrun = 1'b0;
        chk("t3_ovr_clr", 32'(bus.overrun), 32'd0);

        // Full with simultaneous push and pop: both succeed, no overrun.
        for (int i = 0; i < 16; i++) push(8'(i));
        bus.rx_done = 1'b1;
        bus.rx_data = 8'hBB;
        bus.rd_en   = 1'b1;
        step();
        bus.rx_done = 1'b0;
        chk("t4_d0", 32'(bus.rd_data), 32'h00);
        chk("t4_cnt", 32'(bus.count), 32'd16);
        chk("t4_ovr", 32'(bus.overrun), 32'd0);
        for (int i = 1; i < 16; i++) begin
            step();
            chk($sformatf("t4_rd%0d", i), 32'(bus.rd_data), 32'(i));
        end
        step();
        chk("t4_rdBB", 32'(bus.rd_data), 32'hBB);
        bus.rd_en = 1'b0;
        step();
        chk("t4_empty", 32'(bus.empty), 32'd1);

        // Interleaved 20 writes / 20 reads across the wrap, almost_full edges.
        for (int i = 0; i < 12; i++) begin
            push(8'(8'h60 + i));
            chk($sformatf("t5_af_w%0d", i + 1), 32'(bus.almost_full), 32'(i + 1 >= 12));
        end
        for (int i = 0; i < 8; i++) begin
            pop_chk($sformatf("t5_mid%0d", i), 8'(8'h60 + i));
            chk("t5_af_11", 32'(bus.almost_full), 32'd0);
            chk("t5_cnt_11", 32'(bus.count), 32'd11);
            push(8'(8'h60 + 12 + i));
            chk("t5_af_12", 32'(bus.almost_full), 32'd1);
        end
        for (int i = 8; i < 20; i++) pop_chk($sformatf("t5_end%0d", i), 8'(8'h60 + i));
        chk("t5_empty", 32'(bus.empty), 32'd1);

        // Flush beats a simultaneous write.
        for (int i = 0; i < 5; i++) push(8'(8'h90 + i));
        chk("t6_cnt5", 32'(bus.count), 32'd5);
        bus.flush   = 1'b1;
        bus.rx_done = 1'b1;
        bus.rx_data = 8'hCC;
        step();
        bus.flush = 1'b0;
        chk("t6_fl_cnt", 32'(bus.count), 32'd0);
        chk("t6_fl_empty", 32'(bus.empty), 32'd1);
        chk("t6_fl_rdvld", 32'(bus.rd_valid), 32'd0);
        bus.rx_done = 1'b0;
        step();
        chk("t6_fl_nowr", 32'(bus.count), 32'd0);

        // Asynchronous reset mid-fill with rd_valid, rd_data and overrun non-zero.
        for (int i = 0; i < 16; i++) push(8'(8'hD0 + i));
        push(8'hEE);
        pop_chk("t7_pre", 8'hD0);
        chk("t7_pre_ovr", 32'(bus.overrun), 32'd1);
        #2;
        a_resetn = 1'b0;
        #1;
        chk_reset_vals("t7_async");
        step();
        a_resetn = 1'b1;
        step();
        push(8'h77);
        chk("t7_post_cnt", 32'(bus.count), 32'd1);
        pop_chk("t7_post", 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
